// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_B     = 2'd2;
  localparam logic [1:0] DIG_A     = 2'd3;

  // Entry 15 is leftmost in the concatenation.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-high segment pattern, with a forced-blank input.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_OFF : SEG_HEX[i_val];

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode scan driver: A, B and the decimal result {Cout,Sum},
// with anode dead-time between digits and frame-aligned operand updates.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int BLANK_CYC  = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit LZB        = 1'b1
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       Load,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] Sum,
  input  logic       Cout,
  output logic [6:0] Seg,
  output logic [3:0] An
);

  localparam logic [3:0] BC_LOAD = 4'(BLANK_CYC - 1);
  localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_POL  = ACTIVE_LOW ? 4'hF : 4'h0;

  scan_state_t r_state, w_state_next;
  logic [1:0]  r_idx, w_idx_next;
  logic [3:0]  r_bc, w_bc_next;
  logic        r_pend, w_pend_next;
  logic [3:0]  r_disp_a, r_disp_b, r_shd_a, r_shd_b;
  logic [4:0]  r_disp_r, r_shd_r;
  logic [3:0]  w_disp_a_next, w_disp_b_next;
  logic [4:0]  w_disp_r_next;
  logic        w_frame;
  logic [1:0]  w_tens;
  logic [3:0]  w_units;
  logic [3:0]  w_dig_val;
  logic        w_dig_blank;
  logic [6:0]  w_dec_seg, w_seg_raw;
  logic [3:0]  w_an_raw;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_bc_next    = r_bc;
    w_frame      = 1'b0;
    case (r_state)
      SCAN: begin
        if (Tick) begin
          w_idx_next   = r_idx + 2'd1;
          w_bc_next    = BC_LOAD;
          w_state_next = BLANK;
        end
      end
      BLANK: begin
        if (r_bc == 4'd0) begin
          w_state_next = SCAN;
          w_frame      = (r_idx == DIG_UNITS);
        end else begin
          w_bc_next = r_bc - 4'd1;
        end
      end
      default: w_state_next = SCAN;
    endcase
  end

  // A Load landing on the frame edge bypasses the shadow so it shows at once.
  always_comb begin
    w_disp_a_next = r_disp_a;
    w_disp_b_next = r_disp_b;
    w_disp_r_next = r_disp_r;
    w_pend_next   = r_pend;
    if (w_frame && Load) begin
      w_disp_a_next = A;
      w_disp_b_next = B;
      w_disp_r_next = {Cout, Sum};
      w_pend_next   = 1'b0;
    end else if (w_frame) begin
      if (r_pend) begin
        w_disp_a_next = r_shd_a;
        w_disp_b_next = r_shd_b;
        w_disp_r_next = r_shd_r;
      end
      w_pend_next = 1'b0;
    end else if (Load) begin
      w_pend_next = 1'b1;
    end
  end

  always_comb begin
    w_tens  = 2'd0;
    w_units = w_disp_r_next[3:0];
    if (w_disp_r_next >= 5'd30) begin
      w_tens  = 2'd3;
      w_units = 4'(w_disp_r_next - 5'd30);
    end else if (w_disp_r_next >= 5'd20) begin
      w_tens  = 2'd2;
      w_units = 4'(w_disp_r_next - 5'd20);
    end else if (w_disp_r_next >= 5'd10) begin
      w_tens  = 2'd1;
      w_units = 4'(w_disp_r_next - 5'd10);
    end
  end

  always_comb begin
    w_dig_val   = w_units;
    w_dig_blank = 1'b0;
    case (w_idx_next)
      DIG_UNITS: w_dig_val = w_units;
      DIG_TENS: begin
        w_dig_val   = {2'b00, w_tens};
        w_dig_blank = LZB && (w_disp_r_next < 5'd10);
      end
      DIG_B:     w_dig_val = w_disp_b_next;
      DIG_A:     w_dig_val = w_disp_a_next;
      default:   w_dig_val = w_units;
    endcase
  end

  seg7_decoder u_dec (
    .i_val  (w_dig_val),
    .i_blank(w_dig_blank),
    .o_seg  (w_dec_seg)
  );

  // Outputs are registered from next-state values so Seg and An move together.
  assign w_seg_raw = (w_state_next == SCAN) ? w_dec_seg : SEG_OFF;
  assign w_an_raw  = (w_state_next == SCAN) ? (4'b0001 << w_idx_next) : 4'b0000;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state  <= SCAN;
      r_idx    <= 2'd0;
      r_bc     <= 4'd0;
      r_pend   <= 1'b0;
      r_disp_a <= 4'd0;
      r_disp_b <= 4'd0;
      r_disp_r <= 5'd0;
      r_shd_a  <= 4'd0;
      r_shd_b  <= 4'd0;
      r_shd_r  <= 5'd0;
      Seg      <= SEG_HEX[0] ^ SEG_POL;
      An       <= 4'b0001 ^ AN_POL;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_bc     <= w_bc_next;
      r_pend   <= w_pend_next;
      r_disp_a <= w_disp_a_next;
      r_disp_b <= w_disp_b_next;
      r_disp_r <= w_disp_r_next;
      if (Load) begin
        r_shd_a <= A;
        r_shd_b <= B;
        r_shd_r <= {Cout, Sum};
      end
      Seg <= w_seg_raw ^ SEG_POL;
      An  <= w_an_raw ^ AN_POL;
    end
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Multiplexed 7-segment display driver for the 4-bit adder board. It sits directly downstream of the bit-counter clock divider and consumes that divider's one-cycle scan tick. On each tick it advances which of four common-anode digits is lit: operand A, operand B, and the two decimal digits of the 5-bit result. An anode dead-time between digits prevents ghosting. A shadow register applies operand updates only at frame boundaries, so a frame never mixes old and new values.

## Interface
- `BLANK_CYC`, default 2: dead-time cycles with all anodes off after each digit advance; legal range 1..15.
- `ACTIVE_LOW`, default 1: 1 means `Seg` and `An` are driven active-low; 0 means active-high.
- `LZB`, default 1: 1 blanks the result tens digit when the result is below 10.
- `Clk`  in  1  sole clock; all state updates on its rising edge.
- `Clr`  in  1  reset, synchronous and active-high.
- `Tick`  in  1  one-cycle scan strobe from the divider, synchronous to `Clk`.
- `Load`  in  1  one-cycle strobe; captures `A`, `B`, `Sum`, `Cout` into the shadow register.
- `A`  in  4  operand A, displayed in hex.
- `B`  in  4  operand B, displayed in hex.
- `Sum`  in  4  adder sum bits.
- `Cout`  in  1  adder carry; the result is the 5-bit value {Cout,Sum}, range 0..31.
- `Seg`  out  7  segment bus, bit order {g,f,e,d,c,b,a}; registered.
- `An`  out  4  anode enables; bit i lights digit i; registered.

## Operation
- Digit map:
  - digit 0 = result units, (R mod 10).
  - digit 1 = result tens, (R / 10), range 0..3.
  - digit 2 = B, hex 0..F.
  - digit 3 = A, hex 0..F.
- Registers:
  - display register: {A,B,R}, the values currently shown.
  - shadow register: {A,B,R}, the latest captured values.
  - `pend` flag.
  - 2-bit digit index `idx`.
  - FSM state.
  - 4-bit dead-time counter `bc`.
- FSM state SCAN: the `An` bit for `idx` is active; `Seg` shows that digit. `Tick`=1 sets `idx` to idx+1 mod 4, loads `bc` with BLANK_CYC-1, and moves to BLANK.
- FSM state BLANK: all `An` inactive and `Seg` all off. Each cycle decrements `bc`. When `bc`=0, moves to SCAN.
- `Tick` while in BLANK is dropped; it is neither queued nor counted.
- `Load`: the shadow register captures the inputs and `pend` is set to 1. Repeated `Load` before a frame boundary: the last one wins.
- Frame boundary is the BLANK→SCAN transition with `idx`=0. At that edge, if `pend`=1, the display register copies the shadow register and `pend` is cleared.
- `Load` on the frame-boundary cycle itself: the new input values go straight to the display register and to the shadow register; `pend` ends at 0.
- Leading-zero blanking: with `LZB`=1 and R<10, digit 1 shows all segments off while its anode is still driven. Digits 0, 2 and 3 are never blanked.
- `ACTIVE_LOW`=1 inverts both `Seg` and `An` at the output registers only.

## Timing
- Reset (`Clr`=1 at an edge) sets:
  - state = SCAN, `idx` = 0, `bc` = 0, `pend` = 0;
  - display and shadow registers = 0;
  - `An` = 4'b1110 and `Seg` = 7'b1000000 (digit 0 showing "0", active-low).
- `Clr` takes priority over `Tick` and `Load` in the same cycle. `Clr` in the middle of BLANK aborts the dead-time immediately.
- `Tick` sampled at edge t while in SCAN:
  - `An` is all-inactive from edge t through edge t+BLANK_CYC-1, i.e. exactly BLANK_CYC cycles;
  - at edge t+BLANK_CYC the new digit's `An` and `Seg` appear together;
  - `Seg` and `An` never change on different edges.
- Display latency of `Load` is 1 cycle if the `Load` lands on a frame boundary. Otherwise it is the number of cycles until the next frame boundary.
- `idx` wraps 3→0. The `Tick` that wraps it is the one that produces a frame boundary BLANK_CYC cycles later.
- Result arithmetic: tens = 1 if R≥10, 2 if R≥20, 3 if R≥30; units = R − 10·tens. Implemented combinationally from 5 bits; no divider.

## Structure
- Package `seg7_pkg` holds:
  - the FSM state enum {SCAN, BLANK};
  - the 16-entry hex-to-segment constant table, active-high;
  - the `SEG_OFF` constant;
  - the digit index constants `DIG_UNITS`=0, `DIG_TENS`=1, `DIG_B`=2, `DIG_A`=3.
- One combinational sub-module, `seg7_decoder`: a 4-bit value plus a blank flag in, 7-bit active-high segments out. The top level owns the FSM, the registers and the polarity inversion.

## Test plan
- Reset: with `Clr` held for 2 cycles, then released → `An`=1110 and `Seg`=1000000; both remain unchanged with no `Tick`.
- Scan with `BLANK_CYC`=2: four ticks spaced 10 cycles apart →
  - `An` sequence 1110, 1111, 1111, 1101, then on to 1011, 0111, 1110;
  - each blank gap lasts exactly 2 cycles.
- Load A=9, B=8, Sum=0001, Cout=1 (R=17) with `ACTIVE_LOW`=0, then a full frame → digits 0..3 show 7, 1, 8, 9; digit 0 `Seg`=0000111.
- Leading-zero blanking: A=2, B=3, Sum=0101, Cout=0 → digit 1 `Seg` all off with its anode active; digit 0 shows 5.
- Mid-frame `Load` while idx=2 → digits 2 and 3 keep their old values in the current frame; the new values appear only after the next 3→0 wrap.
- `Tick` raised during BLANK → ignored, `idx` unchanged. `Clr` asserted during BLANK → reset state on the next edge.
